// File: rtl/mux_arb_pkg.sv
// Shared types and defaults for the two-requester round-robin arbiter.
package mux_arb_pkg;

  localparam int DATA_W_DEFAULT = 8;
  localparam int CNT_W          = 8;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  // Round-robin pick when both requesters contend: the one not served last.
  function automatic src_e other_src(input src_e s);
    return (s == SRC_A) ? SRC_B : SRC_A;
  endfunction

endpackage

// File: rtl/mux2to1.sv
// Plain combinational two-input data selector.
module mux2to1 #(
  parameter int W = 8
) (
  input  logic         sel_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] y_o
);

  assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux2to1_rr_arbiter.sv
// Two-source round-robin arbiter feeding a single registered output slot,
// with per-source accepted-beat counters.
module mux2to1_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              a_valid_i,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              a_ready_o,
  input  logic              b_valid_i,
  input  logic [DATA_W-1:0] b_data_i,
  output logic              b_ready_o,
  output logic              y_valid_o,
  output logic [DATA_W-1:0] y_data_o,
  output logic              y_src_o,
  input  logic              y_ready_i,
  output logic [CNT_W-1:0]  a_cnt_o,
  output logic [CNT_W-1:0]  b_cnt_o
);

  state_e             state_q, state_d;
  src_e               last_q, last_d;
  src_e               src_q, src_d;
  src_e               grant;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [DATA_W-1:0]  mux_y;
  logic [CNT_W-1:0]   a_cnt_q, a_cnt_d;
  logic [CNT_W-1:0]   b_cnt_q, b_cnt_d;
  logic               load_en;
  logic               accept;

  assign load_en = (state_q == ST_EMPTY) | y_ready_i;

  always_comb begin
    grant = SRC_A;
    if (a_valid_i && b_valid_i) begin
      grant = other_src(last_q);
    end else if (b_valid_i) begin
      grant = SRC_B;
    end
  end

  mux2to1 #(
    .W (DATA_W)
  ) u_mux (
    .sel_i (grant == SRC_B),
    .a_i   (a_data_i),
    .b_i   (b_data_i),
    .y_o   (mux_y)
  );

  // Readies are forced low while reset is asserted, since reset only acts at the edge.
  assign a_ready_o = rst_ni & load_en & a_valid_i & (grant == SRC_A);
  assign b_ready_o = rst_ni & load_en & b_valid_i & (grant == SRC_B);
  assign accept    = a_ready_o | b_ready_o;

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    src_d   = src_q;
    data_d  = data_q;
    a_cnt_d = a_cnt_q;
    b_cnt_d = b_cnt_q;
    if (accept) begin
      state_d = ST_FULL;
      last_d  = grant;
      src_d   = grant;
      data_d  = mux_y;
      if (a_ready_o) a_cnt_d = a_cnt_q + 8'd1;
      if (b_ready_o) b_cnt_d = b_cnt_q + 8'd1;
    end else if (state_q == ST_FULL && y_ready_i) begin
      state_d = ST_EMPTY;
    end
  end

  // Reset leaves last_q at B so requester A wins the first contention.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      last_q  <= SRC_B;
      src_q   <= SRC_A;
      data_q  <= '0;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      src_q   <= src_d;
      data_q  <= data_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
    end
  end

  assign y_valid_o = (state_q == ST_FULL);
  assign y_data_o  = data_q;
  assign y_src_o   = src_q;
  assign a_cnt_o   = a_cnt_q;
  assign b_cnt_o   = b_cnt_q;

endmodule

// File: tb/tb_mux2to1_rr_arbiter.sv
// Bench for mux2to1_rr_arbiter: directed vector table, counter wrap, and
// randomized traffic against a transaction-level reference model.
module tb_mux2to1_rr_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       a_valid_i, b_valid_i, y_ready_i;
  logic [7:0] a_data_i, b_data_i;
  logic       a_ready_o, b_ready_o, y_valid_o, y_src_o;
  logic [7:0] y_data_o, a_cnt_o, b_cnt_o;

  int tests  = 0;
  int failed = 0;

  always #5 clk_i = ~clk_i;

  mux2to1_rr_arbiter #(.DATA_W(8)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .a_valid_i (a_valid_i),
    .a_data_i  (a_data_i),
    .a_ready_o (a_ready_o),
    .b_valid_i (b_valid_i),
    .b_data_i  (b_data_i),
    .b_ready_o (b_ready_o),
    .y_valid_o (y_valid_o),
    .y_data_o  (y_data_o),
    .y_src_o   (y_src_o),
    .y_ready_i (y_ready_i),
    .a_cnt_o   (a_cnt_o),
    .b_cnt_o   (b_cnt_o)
  );

  typedef struct {
    logic       rst_n;
    logic       a_v;
    logic [7:0] a_d;
    logic       b_v;
    logic [7:0] b_d;
    logic       y_r;
    logic       exp_a_rdy;
    logic       exp_b_rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_src;
    logic [7:0] exp_acnt;
    logic [7:0] exp_bcnt;
  } vec_t;

  vec_t vecs[$];

  // Transaction-level model: the output slot is a 0/1-deep buffer, and the
  // arbiter remembers who was served last.
  int  m_slot_full;
  int  m_slot_data;
  int  m_slot_src;
  int  m_last_served;
  int  m_cnt[2];

  task automatic addVec(input logic rn, input logic av, input logic [7:0] ad,
                        input logic bv, input logic [7:0] bd, input logic yr,
                        input logic ear, input logic ebr, input logic ev,
                        input logic [7:0] ed, input logic es,
                        input logic [7:0] eac, input logic [7:0] ebc);
    vec_t v;
    v = '{rn, av, ad, bv, bd, yr, ear, ebr, ev, ed, es, eac, ebc};
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle's inputs just after the edge, then settle to mid-cycle.
  task automatic applyStimulus(input logic rn, input logic av, input logic [7:0] ad,
                               input logic bv, input logic [7:0] bd, input logic yr);
    rst_ni    = rn;
    a_valid_i = av;
    a_data_i  = ad;
    b_valid_i = bv;
    b_data_i  = bd;
    y_ready_i = yr;
    #4;
  endtask

  task automatic nextEdge();
    @(posedge clk_i);
    #1;
  endtask

  task automatic modelReset();
    m_slot_full   = 0;
    m_slot_data   = 0;
    m_slot_src    = 0;
    m_last_served = 1;
    m_cnt[0]      = 0;
    m_cnt[1]      = 0;
  endtask

  // Returns which requester the model would accept this cycle: 0, 1, or -1.
  function automatic int modelWinner(input logic rn, input logic av, input logic bv,
                                     input logic yr);
    if (!rn) return -1;
    if (m_slot_full != 0 && !yr) return -1;
    if (av && bv) return 1 - m_last_served;
    if (av) return 0;
    if (bv) return 1;
    return -1;
  endfunction

  task automatic modelEdge(input logic rn, input logic av, input logic [7:0] ad,
                           input logic bv, input logic [7:0] bd, input logic yr);
    int w;
    w = modelWinner(rn, av, bv, yr);
    if (!rn) begin
      modelReset();
    end else if (w >= 0) begin
      m_slot_full   = 1;
      m_slot_data   = (w == 0) ? int'(ad) : int'(bd);
      m_slot_src    = w;
      m_last_served = w;
      m_cnt[w]      = (m_cnt[w] + 1) % 256;
    end else if (yr) begin
      m_slot_full = 0;
    end
  endtask

  task automatic modelCycle(input logic rn, input logic av, input logic [7:0] ad,
                            input logic bv, input logic [7:0] bd, input logic yr);
    int w;
    applyStimulus(rn, av, ad, bv, bd, yr);
    w = modelWinner(rn, av, bv, yr);
    checkOutput("rnd_a_ready", int'(a_ready_o), int'(w == 0));
    checkOutput("rnd_b_ready", int'(b_ready_o), int'(w == 1));
    nextEdge();
    modelEdge(rn, av, ad, bv, bd, yr);
    checkOutput("rnd_y_valid", int'(y_valid_o), m_slot_full);
    if (m_slot_full != 0) begin
      checkOutput("rnd_y_data", int'(y_data_o), m_slot_data);
      checkOutput("rnd_y_src", int'(y_src_o), m_slot_src);
    end
    checkOutput("rnd_a_cnt", int'(a_cnt_o), m_cnt[0]);
    checkOutput("rnd_b_cnt", int'(b_cnt_o), m_cnt[1]);
  endtask

  initial begin
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

    // Reset with both valids high, contention, single source, backpressure,
    // reset during a stall, and a valid dropping without being accepted.
    addVec(0, 1, 8'hAA, 1, 8'hFF, 1,  0, 0,  0, 8'h00, 0, 8'd0, 8'd0);
    addVec(0, 1, 8'hAA, 1, 8'hFF, 1,  0, 0,  0, 8'h00, 0, 8'd0, 8'd0);
    addVec(1, 1, 8'hAA, 1, 8'hFF, 1,  1, 0,  1, 8'hAA, 0, 8'd1, 8'd0);
    addVec(1, 1, 8'hAA, 1, 8'hFF, 1,  0, 1,  1, 8'hFF, 1, 8'd1, 8'd1);
    addVec(1, 1, 8'hAA, 1, 8'hFF, 1,  1, 0,  1, 8'hAA, 0, 8'd2, 8'd1);
    addVec(1, 1, 8'hAA, 1, 8'hFF, 1,  0, 1,  1, 8'hFF, 1, 8'd2, 8'd2);
    addVec(1, 0, 8'h00, 0, 8'h00, 1,  0, 0,  0, 8'h00, 0, 8'd2, 8'd2);
    addVec(0, 0, 8'h00, 0, 8'h00, 0,  0, 0,  0, 8'h00, 0, 8'd0, 8'd0);
    addVec(1, 1, 8'hAA, 0, 8'h00, 1,  1, 0,  1, 8'hAA, 0, 8'd1, 8'd0);
    addVec(1, 1, 8'h55, 0, 8'h00, 1,  1, 0,  1, 8'h55, 0, 8'd2, 8'd0);
    addVec(1, 1, 8'h66, 1, 8'hFF, 0,  0, 0,  1, 8'h55, 0, 8'd2, 8'd0);
    addVec(1, 1, 8'h66, 1, 8'hFF, 0,  0, 0,  1, 8'h55, 0, 8'd2, 8'd0);
    addVec(1, 1, 8'h66, 1, 8'hFF, 0,  0, 0,  1, 8'h55, 0, 8'd2, 8'd0);
    addVec(1, 1, 8'h66, 1, 8'hFF, 1,  0, 1,  1, 8'hFF, 1, 8'd2, 8'd1);
    addVec(1, 0, 8'h00, 1, 8'h11, 0,  0, 0,  1, 8'hFF, 1, 8'd2, 8'd1);
    addVec(0, 1, 8'h66, 1, 8'h11, 0,  0, 0,  0, 8'h00, 0, 8'd0, 8'd0);
    addVec(1, 1, 8'h3C, 1, 8'hC3, 1,  1, 0,  1, 8'h3C, 0, 8'd1, 8'd0);
    addVec(1, 0, 8'h00, 0, 8'h00, 0,  0, 0,  1, 8'h3C, 0, 8'd1, 8'd0);

    @(posedge clk_i);
    #1;
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst_n, vecs[i].a_v, vecs[i].a_d,
                    vecs[i].b_v, vecs[i].b_d, vecs[i].y_r);
      checkOutput($sformatf("v%0d_a_ready", i), int'(a_ready_o), int'(vecs[i].exp_a_rdy));
      checkOutput($sformatf("v%0d_b_ready", i), int'(b_ready_o), int'(vecs[i].exp_b_rdy));
      checkOutput($sformatf("v%0d_excl", i), int'(a_ready_o & b_ready_o), 0);
      nextEdge();
      checkOutput($sformatf("v%0d_y_valid", i), int'(y_valid_o), int'(vecs[i].exp_valid));
      if (vecs[i].exp_valid || !vecs[i].rst_n) begin
        checkOutput($sformatf("v%0d_y_data", i), int'(y_data_o), int'(vecs[i].exp_data));
        checkOutput($sformatf("v%0d_y_src", i), int'(y_src_o), int'(vecs[i].exp_src));
      end
      checkOutput($sformatf("v%0d_a_cnt", i), int'(a_cnt_o), int'(vecs[i].exp_acnt));
      checkOutput($sformatf("v%0d_b_cnt", i), int'(b_cnt_o), int'(vecs[i].exp_bcnt));
    end

    // Counter wrap: one B beat, then 256 A beats bring a_cnt back to zero.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
    nextEdge();
    applyStimulus(1'b1, 1'b0, 8'h00, 1'b1, 8'h77, 1'b1);
    nextEdge();
    for (int n = 0; n < 256; n++) begin
      applyStimulus(1'b1, 1'b1, 8'(n), 1'b0, 8'h00, 1'b1);
      nextEdge();
      if (n == 254) checkOutput("wrap_a_cnt_255", int'(a_cnt_o), 255);
    end
    checkOutput("wrap_a_cnt_0", int'(a_cnt_o), 0);
    checkOutput("wrap_b_cnt", int'(b_cnt_o), 1);
    checkOutput("wrap_last_data", int'(y_data_o), 255);

    // Randomized traffic against the model, starting from a clean reset.
    modelCycle(1'b0, 1'b1, 8'h00, 1'b1, 8'h00, 1'b1);
    for (int n = 0; n < 600; n++) begin
      logic rn;
      rn = ($urandom_range(0, 49) != 0);
      modelCycle(rn, 1'($urandom), 8'($urandom), 1'($urandom), 8'($urandom),
                 ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mux2to1_rr_arbiter.md
MUX2TO1_RR_ARBITER -- requirements
Module: mux2to1_rr_arbiter

Interface
REQ-001 Parameter: DATA_W, default 8, width of every data port.
REQ-002 The block SHALL have one clock; reset is synchronous and active-low: clk_i and rst_ni.
REQ-003 clk_i  input  1  rising-edge clock for all state.
REQ-004 rst_ni  input  1  synchronous active-low reset.
REQ-005 a_valid_i  input  1  requester A offers a_data_i.
REQ-006 a_data_i  input  DATA_W  requester A data.
REQ-007 a_ready_o  output  1  A beat accepted this cycle when a_valid_i & a_ready_o.
REQ-008 b_valid_i  input  1  requester B offers b_data_i.
REQ-009 b_data_i  input  DATA_W  requester B data.
REQ-010 b_ready_o  output  1  B beat accepted this cycle when b_valid_i & b_ready_o.
REQ-011 y_valid_o  output  1  registered output beat valid.
REQ-012 y_data_o  output  DATA_W  registered output data.
REQ-013 y_src_o  output  1  source of the current output beat (0=A, 1=B).
REQ-014 y_ready_i  input  1  consumer accepts the beat when y_valid_o & y_ready_i.
REQ-015 a_cnt_o / b_cnt_o  output  8 each  count of accepted beats per source.

Function
REQ-016 load_en SHALL be !y_valid_o | y_ready_i (output slot free or draining this cycle).
REQ-017 Grant SHALL be combinational: only A valid -> A; only B valid -> B; both valid -> source not equal to last_grant.
REQ-018 a_ready_o SHALL be load_en & grant==A & a_valid_i; b_ready_o likewise for B. The two readies are never high together.
REQ-019 On acceptance, y_data_o, y_src_o and y_valid_o=1 SHALL be loaded at the next edge (latency 1 cycle).
REQ-020 last_grant SHALL update to the accepted source only on acceptance; otherwise it holds.
REQ-021 While y_valid_o=1 & y_ready_i=0, y_data_o and y_src_o SHALL hold and both readies SHALL be 0.
REQ-022 Drain with no new acceptance SHALL clear y_valid_o next cycle. Drain plus acceptance in the same cycle SHALL reload with no bubble (full throughput, 1 beat/cycle).
REQ-023 States: EMPTY (y_valid_o=0) and FULL (y_valid_o=1). Transitions: EMPTY->FULL on accept; FULL->EMPTY on drain without accept; FULL->FULL on stall, or on drain with accept.
REQ-024 a_cnt_o / b_cnt_o SHALL increment by 1 per accepted beat of that source, wrapping 255->0.
REQ-025 Requester valid dropping without acceptance SHALL have no effect on state.

Reset
REQ-026 While rst_ni=0 at an edge: y_valid_o=0, y_data_o=0, y_src_o=0, last_grant=B (so A wins the first contention), a_cnt_o=b_cnt_o=0.
REQ-027 Reset mid-transfer SHALL discard the held beat; readies SHALL be 0 during reset.

Structure
REQ-028 Shared package mux_arb_pkg SHALL hold DATA_W default and enum src_e {SRC_A=0, SRC_B=1}.
REQ-029 The data select SHALL instantiate the existing mux2to1 sub-module (sel = grant); arbitration and registers stay in this block.

Verification
REQ-030 Reset: hold rst_ni=0 for 2 cycles with both valids high -> all outputs 0, both readies 0.
REQ-031 Single source: A sends 0xAA with y_ready_i=1 -> next cycle y_valid_o=1, y_data_o=0xAA, y_src_o=0, a_cnt_o=1.
REQ-032 Contention: A=0xAA and B=0xFF held valid, y_ready_i=1 -> outputs alternate 0xAA,0xFF,0xAA,... every cycle, starting with A.
REQ-033 Backpressure: output FULL with 0x55, y_ready_i=0 for 3 cycles -> y_data_o stays 0x55, readies 0; then y_ready_i=1 -> pending beat loads with no bubble.
REQ-034 Counter wrap: 256 accepted A beats -> a_cnt_o returns to 0, b_cnt_o unchanged.
REQ-035 Mid-stall reset: FULL with y_ready_i=0, assert rst_ni=0 -> y_valid_o=0 next edge, and A wins the first contention after release.
